// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular-exponentiation slice.
// Holds the default widths and the controller and handshake state encodings.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;
    localparam int RSA_EXP_W = 256;
    localparam int RSA_CNT_W = 9;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_REDUCE = 3'd2;
    localparam logic [2:0] ST_SCAN   = 3'd3;
    localparam logic [2:0] ST_SQUARE = 3'd4;
    localparam logic [2:0] ST_MULT   = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_FINISH = 3'd7;

    localparam logic [1:0] HS_ISSUE    = 2'd0;
    localparam logic [1:0] HS_WAIT_V   = 2'd1;
    localparam logic [1:0] HS_WAIT_REL = 2'd2;

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// Bus between the exponentiation controller (master) and the Barrett multiplier (slave).
interface rsa_modexp_ctrl_if #(parameter int WIDTH = rsa_pkg::RSA_WIDTH);

    logic             mul_en;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_n;
    logic [WIDTH-1:0] mul_r;
    logic             mul_valid;

    modport master (
        output mul_en, mul_a, mul_b, mul_n,
        input  mul_r, mul_valid
    );

    modport slave (
        input  mul_en, mul_a, mul_b, mul_n,
        output mul_r, mul_valid
    );

endinterface

// File: rtl/rsa_mul_seq.sv
// Runs one multiplier transaction per go pulse: issue, wait for valid, wait for release.
// ack pulses only after valid has dropped, so the next go can be issued right away.
module rsa_mul_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ack,
    output logic [WIDTH-1:0] product,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_r,
    input  logic             mul_valid
);

    logic [1:0] hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs      <= HS_ISSUE;
            ack     <= 1'b0;
            product <= '0;
            mul_en  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            ack <= 1'b0;
            case (hs)
                HS_ISSUE: begin
                    if (go) begin
                        mul_a  <= a;
                        mul_b  <= b;
                        mul_en <= 1'b1;
                        hs     <= HS_WAIT_V;
                    end
                end
                HS_WAIT_V: begin
                    if (mul_valid) begin
                        product <= mul_r;
                        mul_en  <= 1'b0;
                        hs      <= HS_WAIT_REL;
                    end
                end
                HS_WAIT_REL: begin
                    if (!mul_valid) begin
                        ack <= 1'b1;
                        hs  <= HS_ISSUE;
                    end
                end
                default: hs <= HS_ISSUE;
            endcase
        end
    end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod n
// through an external multiplier reached via rsa_mul_seq.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int EXP_W = RSA_EXP_W,
    parameter int CNT_W = RSA_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   base,
    input  logic [EXP_W-1:0]   exp,
    input  logic [WIDTH-1:0]   n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result,
    rsa_modexp_ctrl_if.master  mul
);

    localparam int IDX_W = $clog2(EXP_W);

    logic [2:0]       state;
    logic [WIDTH-1:0] base_q;
    logic [EXP_W-1:0] exp_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] b_red;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] idx;
    logic             issued;
    logic             go;
    logic             ack;
    logic             exp_bit;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] product;
    logic             seq_en;
    logic [WIDTH-1:0] seq_a;
    logic [WIDTH-1:0] seq_b;

    assign exp_bit = exp_q[idx[IDX_W-1:0]];
    assign go      = ((state == ST_REDUCE) || (state == ST_SQUARE) || (state == ST_MULT)) && !issued;

    // REDUCE multiplies by one purely to bring a base >= n into range.
    always_comb begin
        op_a = acc;
        op_b = acc;
        case (state)
            ST_REDUCE: begin
                op_a = base_q;
                op_b = WIDTH'(1);
            end
            ST_MULT:   op_b = b_red;
            default:   ;
        endcase
    end

    rsa_mul_seq #(.WIDTH(WIDTH)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .a         (op_a),
        .b         (op_b),
        .ack       (ack),
        .product   (product),
        .mul_en    (seq_en),
        .mul_a     (seq_a),
        .mul_b     (seq_b),
        .mul_r     (mul.mul_r),
        .mul_valid (mul.mul_valid)
    );

    assign mul.mul_en = seq_en;
    assign mul.mul_a  = seq_a;
    assign mul.mul_b  = seq_b;
    assign mul.mul_n  = n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            base_q <= '0;
            exp_q  <= '0;
            n_q    <= '0;
            b_red  <= '0;
            acc    <= '0;
            idx    <= '0;
            issued <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (go)
                issued <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        n_q    <= n;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (n_q == '0) begin
                        err   <= 1'b1;
                        acc   <= '0;
                        state <= ST_FINISH;
                    end else if (exp_q == '0) begin
                        acc   <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state <= ST_FINISH;
                    end else begin
                        state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (ack) begin
                        issued <= 1'b0;
                        b_red  <= product;
                        idx    <= CNT_W'(EXP_W - 1);
                        state  <= ST_SCAN;
                    end
                end
                // The leading set bit costs no multiply: acc simply starts at b_red.
                ST_SCAN: begin
                    if (exp_bit) begin
                        acc <= b_red;
                        if (idx == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= ST_SQUARE;
                        end
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_SQUARE: begin
                    if (ack) begin
                        issued <= 1'b0;
                        acc    <= product;
                        state  <= exp_bit ? ST_MULT : ST_NEXT;
                    end
                end
                ST_MULT: begin
                    if (ack) begin
                        issued <= 1'b0;
                        acc    <= product;
                        state  <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx == '0) begin
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= ST_SQUARE;
                    end
                end
                ST_FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
